mem_burst_master: RTL and testbench

//  Initiator for mem_mod's port interface (clk, rd_en/wr_en, rd_addr/wr_addr,
//  wr_data, rd_data). Converts one command (addr, len, direction) into a

---
 rtl/mem_burst_master.sv | 196 +++++++++++++++++++
 tb/tb_mem_burst_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// mem_burst_master: turns one (addr, len, dir) command into a burst of
// mem_mod accesses, bridged to valid/ready write and read streams.
module mem_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADDR = 4,
  localparam int ADDRSIZE = $clog2(MAX_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDRSIZE-1:0]   cmd_addr,
  input  logic [ADDRSIZE:0]     cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDRSIZE-1:0]   mem_rd_addr,
  output logic                  mem_wr_en,
  output logic [ADDRSIZE-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(MAX_ADDR - 1);
  localparam logic [ADDRSIZE:0]   LEN_MAX   = (ADDRSIZE+1)'(MAX_ADDR);

  state_t state, state_nxt;

  logic [ADDRSIZE-1:0]   addr;
  logic [ADDRSIZE-1:0]   addr_inc;
  logic [ADDRSIZE:0]     remain;
  logic [ADDRSIZE:0]     len_clamped;
  logic                  last_word;
  logic                  cmd_hs;
  logic                  wr_hs;
  logic                  rd_issue;
  logic                  rd_pend;

  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;
  logic                  fifo_empty;
  logic                  pop;
  logic                  bypass;
  logic                  push;
  logic                  fifo_pop;
  logic [2:0]            outstanding_nxt;

  assign addr_inc    = (addr == LAST_ADDR) ? '0 : addr + ADDRSIZE'(1);
  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign last_word   = remain == (ADDRSIZE+1)'(1);

  // Returning data bypasses an empty FIFO so reads stream at 1 word/cycle.
  assign fifo_empty  = fifo_cnt == 2'd0;
  assign rdata_valid = !fifo_empty || rd_pend;
  assign rdata       = fifo_empty ? mem_rd_data : fifo[rd_ptr];
  assign pop         = rdata_valid && rdata_ready;
  assign bypass      = fifo_empty && rd_pend && rdata_ready;
  assign push        = rd_pend && !bypass;
  assign fifo_pop    = !fifo_empty && rdata_ready;

  // Words still owed to the stream after this edge, before any new issue.
  assign outstanding_nxt = 3'(fifo_cnt) + 3'(mem_rd_en)
                         + 3'(rd_pend) - 3'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    cmd_hs      = 1'b0;
    wr_hs       = 1'b0;
    rd_issue    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        cmd_hs    = cmd_valid;
        if (cmd_valid) begin
          if (len_clamped == '0) begin
            state_nxt = S_DONE;
          end else if (cmd_write) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_READ;
          end
        end
      end
      S_WRITE: begin
        wdata_ready = 1'b1;
        wr_hs       = wdata_valid;
        if (wdata_valid && last_word) begin
          state_nxt = S_DONE;
        end
      end
      S_READ: begin
        rd_issue = outstanding_nxt < 3'd2;
        if (rd_issue && last_word) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outstanding_nxt == 3'd0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      remain <= '0;
    end else if (cmd_hs) begin
      addr   <= cmd_addr;
      remain <= len_clamped;
    end else if (wr_hs || rd_issue) begin
      addr   <= addr_inc;
      remain <= remain - (ADDRSIZE+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      rd_pend     <= 1'b0;
    end else begin
      mem_wr_en <= wr_hs;
      mem_rd_en <= rd_issue;
      rd_pend   <= mem_rd_en;
      if (wr_hs) begin
        mem_wr_addr <= addr;
        mem_wr_data <= wdata;
      end
      if (rd_issue) begin
        mem_rd_addr <= addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo[0]  <= '0;
      fifo[1]  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= mem_rd_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (fifo_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(fifo_pop);
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master with a behavioural mem_mod model
// and a word-array reference of memory contents.
module tb_mem_burst_master;
  localparam int DW = 8;
  localparam int MA = 4;
  localparam int AW = $clog2(MA);

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rdata_valid;
  logic          rdata_ready;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;

  logic [DW-1:0] mem [MA] = '{default: '0};
  int            ref_mem [MA];
  logic [7:0]    wbuf [4];
  wr_t           exp_wr_q [$];
  int            exp_rd_q [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rmode = 0;
  int wr_tot = 0, rd_tot = 0, rden_tot = 0, done_tot = 0;
  int wr_first = 0, wr_last = 0, rd_first = 0, rd_last = 0;
  int wr_mark = 0, rd_mark = 0;
  int d0;

  always #5 clk = ~clk;

  mem_burst_master #(
    .DATA_WIDTH(DW),
    .MAX_ADDR(MA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata(wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata(rdata),
    .busy(busy),
    .done(done),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // mem_mod stand-in: registered read, synchronous write, no reset
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: rdata_ready = 1'b1;
        1: rdata_ready = 1'($urandom_range(0, 1));
        default: rdata_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr_en || mem_rd_en)
        chk("rd_wr_exclusive", 32'(mem_wr_en & mem_rd_en), 0);
      if (mem_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_wr: addr %0d data %0d, none expected",
                   mem_wr_addr, mem_wr_data);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          chk("wr_addr", 32'(mem_wr_addr), e.addr);
          chk("wr_data", 32'(mem_wr_data), e.data);
        end
        if (wr_tot == wr_mark) wr_first = cyc;
        wr_last = cyc;
        wr_tot++;
      end
      if (mem_rd_en) rden_tot++;
      if (rdata_valid && rdata_ready) begin
        if (exp_rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rdata: got %0d, none expected", rdata);
        end else begin
          chk("rdata", 32'(rdata), exp_rd_q.pop_front());
        end
        if (rd_tot == rd_mark) rd_first = cyc;
        rd_last = cyc;
        rd_tot++;
      end
      if (done) done_tot++;
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mem_wr_en"}, 32'(mem_wr_en), 0);
    chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_rdata_valid"}, 32'(rdata_valid), 0);
    chk({tag, "_wdata_ready"}, 32'(wdata_ready), 0);
  endtask

  task automatic run_cmd(input bit wr, input int addr, input int len,
                         input bit gapless, input int hold);
    int eff, n, t, last_hs, hs_cyc, dd, re0, ev_last, span;
    eff = (len > MA) ? MA : len;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    wr_mark = wr_tot;
    rd_mark = rd_tot;
    dd = done_tot;
    re0 = rden_tot;
    for (int i = 0; i < eff; i++) begin
      int a;
      a = (addr + i) % MA;
      if (wr) begin
        exp_wr_q.push_back(wr_t'{a, int'(wbuf[i])});
        ref_mem[a] = int'(wbuf[i]);
      end else begin
        exp_rd_q.push_back(ref_mem[a]);
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = addr[AW-1:0];
    cmd_len = len[AW:0];
    @(negedge clk);
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr = AW'($urandom);
    cmd_len = (AW+1)'($urandom);
    chk("busy_after_cmd", 32'(busy), 1);
    last_hs = hs_cyc;
    if (wr) begin
      n = 0;
      t = 0;
      while (n < eff && t < 400) begin
        wdata = wbuf[n];
        wdata_valid = gapless ? 1'b1 : ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (wdata_valid && wdata_ready) begin
          n++;
          last_hs = cyc;
        end
        @(posedge clk);
        #1;
        t++;
      end
      wdata_valid = 1'b0;
      chk("wr_accepted", n, eff);
    end else if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("rden_backpressure", rden_tot - re0, 2);
      chk("rdata_valid_held", 32'(rdata_valid), 1);
      if (exp_rd_q.size() > 0)
        chk("rdata_held", 32'(rdata), exp_rd_q[0]);
      rmode = 0;
    end
    t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done), 1);
    chk("busy_with_done", 32'(busy), 1);
    if (eff == 0) ev_last = hs_cyc;
    else if (wr) ev_last = last_hs;
    else ev_last = rd_last;
    chk("done_timing", cyc, ev_last + 1);
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_count", done_tot - dd, 1);
    if (wr) begin
      chk("wr_count", wr_tot - wr_mark, eff);
    end else begin
      chk("rd_count", rd_tot - rd_mark, eff);
      chk("rden_count", rden_tot - re0, eff);
    end
    chk("wr_q_empty", exp_wr_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    if (gapless && eff > 1) begin
      span = wr ? (wr_last - wr_first + 1) : (rd_last - rd_first + 1);
      chk(wr ? "wr_consecutive" : "rd_consecutive", span, eff);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MA; i++) ref_mem[i] = 0;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    wbuf = '{8'd128, 8'd56, 8'd74, 8'd200};
    run_cmd(1'b1, 0, 4, 1'b1, 0);
    run_cmd(1'b0, 0, 4, 1'b1, 0);

    wbuf = '{8'd1, 8'd2, 8'd3, 8'd0};
    run_cmd(1'b1, 3, 3, 1'b1, 0);
    run_cmd(1'b0, 0, 4, 1'b1, 0);

    wbuf = '{8'd128, 8'd56, 8'd74, 8'd200};
    run_cmd(1'b1, 0, 4, 1'b1, 0);
    rmode = 2;
    run_cmd(1'b0, 0, 4, 1'b0, 6);

    run_cmd(1'b1, 2, 0, 1'b1, 0);
    run_cmd(1'b0, 1, 0, 1'b1, 0);

    // Abort a write burst after its second word
    wbuf = '{8'd11, 8'd22, 8'd33, 8'd44};
    d0 = done_tot;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = '0;
    cmd_len = (AW+1)'(4);
    exp_wr_q.push_back(wr_t'{0, 11});
    exp_wr_q.push_back(wr_t'{1, 22});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wdata_valid = 1'b1;
    wdata = 8'd11;
    @(posedge clk);
    #1;
    wdata = 8'd22;
    @(posedge clk);
    #1;
    wdata_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    ref_mem[0] = 11;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_tot - d0, 0);
    chk("abort_wr_q", exp_wr_q.size(), 0);
    rst_n = 1'b1;
    run_cmd(1'b0, 0, 4, 1'b1, 0);

    wbuf = '{8'd9, 8'd8, 8'd7, 8'd6};
    run_cmd(1'b1, 1, 7, 1'b1, 0);
    run_cmd(1'b0, 2, 5, 1'b1, 0);

    for (int k = 0; k < 40; k++) begin
      bit w;
      int a, l, m;
      w = 1'($urandom);
      a = $urandom_range(0, MA - 1);
      l = $urandom_range(0, 2 * MA - 1);
      m = $urandom_range(0, 1);
      rmode = m;
      for (int i = 0; i < MA; i++) wbuf[i] = 8'($urandom);
      run_cmd(w, a, l, m == 0, 0);
    end
    rmode = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
